// File: rtl/axil_slave_mem.sv
// axil_slave_mem: AXI4-Lite slave over a byte-lane-writable word memory.
// Define AXIL_SLV_OOR_RESP_EN to answer out-of-range accesses with SLVERR
// instead of wrapping the word index modulo DEPTH_WORDS.
module axil_slave_mem #(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 12,
   parameter int DEPTH_WORDS = 256
) (
   input  logic                ACLK,
   input  logic                ARESET,
   input  logic                AWVALID,
   output logic                AWREADY,
   input  logic [ADDR_W-1:0]   AWADDR,
   input  logic                WVALID,
   output logic                WREADY,
   input  logic [DATA_W-1:0]   WDATA,
   input  logic [DATA_W/8-1:0] WSTRB,
   output logic                BVALID,
   input  logic                BREADY,
   output logic [1:0]          BRESP,
   input  logic                ARVALID,
   output logic                ARREADY,
   input  logic [ADDR_W-1:0]   ARADDR,
   output logic                RVALID,
   input  logic                RREADY,
   output logic [DATA_W-1:0]   RDATA,
   output logic [1:0]          RRESP
);
   localparam int STRB_W = DATA_W / 8;
   localparam int OFF_W  = $clog2(STRB_W);
   localparam int MW     = $clog2(DEPTH_WORDS);

   typedef enum logic {WR_COLLECT, WR_RESP} wr_state_t;
   typedef enum logic {RD_IDLE, RD_RESP} rd_state_t;

   wr_state_t           wr_state, wr_next;
   rd_state_t           rd_state, rd_next;
   logic                up, aw_held, w_held, commit, aw_hs, w_hs, ar_hs, wr_oor, rd_oor;
   logic [ADDR_W-1:0]   aw_addr;
   logic [DATA_W-1:0]   w_data;
   logic [STRB_W-1:0]   w_strb;
   logic [DATA_W-1:0]   mem [DEPTH_WORDS];

   function automatic logic [MW-1:0] widx(input logic [ADDR_W-1:0] a);
      return MW'(32'(a[ADDR_W-1:OFF_W]) % DEPTH_WORDS);
   endfunction

`ifdef AXIL_SLV_OOR_RESP_EN
   function automatic logic oor(input logic [ADDR_W-1:0] a);
      return 32'(a[ADDR_W-1:OFF_W]) >= DEPTH_WORDS;
   endfunction
   assign wr_oor = oor(aw_addr);
   assign rd_oor = oor(ARADDR);
`else
   assign wr_oor = 1'b0;
   assign rd_oor = 1'b0;
`endif

   assign aw_hs = AWVALID && AWREADY;
   assign w_hs  = WVALID && WREADY;
   assign ar_hs = ARVALID && ARREADY;

   // Write FSM: collect AW and W in any order, commit, then hold B until accepted
   always_comb begin
      commit  = wr_state == WR_COLLECT && aw_held && w_held;
      wr_next = commit ? WR_RESP : (wr_state == WR_RESP && BREADY) ? WR_COLLECT : wr_state;
      AWREADY = up && wr_state == WR_COLLECT && !aw_held;
      WREADY  = up && wr_state == WR_COLLECT && !w_held;
      BVALID  = wr_state == WR_RESP;
   end

   // Read FSM: accept AR when idle, hold R until accepted
   always_comb begin
      rd_next = (rd_state == RD_IDLE && ar_hs) ? RD_RESP : (rd_state == RD_RESP && RREADY) ? RD_IDLE : rd_state;
      ARREADY = up && rd_state == RD_IDLE;
      RVALID  = rd_state == RD_RESP;
   end

   // State registers for both channels
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         wr_state <= WR_COLLECT;
         rd_state <= RD_IDLE;
      end else begin
         wr_state <= wr_next;
         rd_state <= rd_next;
      end
   end

   // Held AW/W payloads, registered responses; up keeps readies low for the cycle after reset
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         up      <= 1'b0;
         aw_held <= 1'b0;
         w_held  <= 1'b0;
         BRESP   <= 2'b00;
         RDATA   <= '0;
         RRESP   <= 2'b00;
      end else begin
         up <= 1'b1;
         if (aw_hs) begin
            aw_held <= 1'b1;
            aw_addr <= AWADDR;
         end
         if (w_hs) begin
            w_held <= 1'b1;
            w_data <= WDATA;
            w_strb <= WSTRB;
         end
         if (commit) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            BRESP   <= wr_oor ? 2'b10 : 2'b00;
         end
         if (ar_hs) begin
            RDATA <= rd_oor ? '0 : mem[widx(ARADDR)];
            RRESP <= rd_oor ? 2'b10 : 2'b00;
         end
      end
   end

   // Byte-lane masked commit; memory contents survive reset
   always_ff @(posedge ACLK) begin
      if (commit && !ARESET && !wr_oor)
         for (int b = 0; b < STRB_W; b++)
            if (w_strb[b]) mem[widx(aw_addr)][8*b +: 8] <= w_data[8*b +: 8];
   end
endmodule
